// File: rtl/wr_node_cpu_cb.sv
// wr_node_cpu_cb: instruction RAM owner, reset/enable generator and timestamp port for one WR node CPU.
// Optional IRAM readback to the CSR block is built in when WRN_CPU_CB_READBACK_EN is defined.
module wr_node_cpu_cb #(
  parameter int g_iram_size = 16384,
  parameter int g_cpu_id    = 0,
  localparam int NW = g_iram_size / 4,
  localparam int AW = $clog2(NW)
) (
  input  logic          clk_sys_i,
  input  logic          rst_n_i,
  input  logic [39:0]   tm_tai_i,
  input  logic [27:0]   tm_cycles_i,
  input  logic [3:0]    csr_core_sel_i,
  input  logic [7:0]    csr_enable_i,
  input  logic [7:0]    csr_reset_i,
  input  logic [19:0]   csr_uaddr_i,
  input  logic [31:0]   csr_udata_i,
  input  logic          csr_udata_load_i,
  output logic [31:0]   csr_udata_o,
  input  logic          im_rd_i,
  input  logic [AW-1:0] im_addr_i,
  output logic [31:0]   im_data_o,
  input  logic          dm_rd_i,
  input  logic [1:0]    dm_addr_i,
  output logic [31:0]   dm_data_o,
  output logic          cpu_rst_n_o,
  output logic          cpu_en_o
);

  logic [31:0]   iram [NW];
  logic          sel;
  logic          rst_bit;
  logic          iram_we;
  logic [AW-1:0] uaddr;
  logic          unused_csr_bits;

  logic          cpu_rst_n_d, cpu_rst_n_q;
  logic          cpu_en_d, cpu_en_q;
  logic [31:0]   im_data_d, im_data_q;
  logic [31:0]   dm_data_d, dm_data_q;
  logic [7:0]    shadow_tai_d, shadow_tai_q;
  logic [27:0]   shadow_cyc_d, shadow_cyc_q;

  assign sel     = (csr_core_sel_i == 4'(g_cpu_id));
  assign rst_bit = csr_reset_i[g_cpu_id];
  assign uaddr   = csr_uaddr_i[AW-1:0];
  // Uploads only while the core is held in reset, and never during block reset.
  assign iram_we = csr_udata_load_i & sel & rst_bit & rst_n_i;

  // Only this core's CSR bits and the low address bits are meaningful here.
  assign unused_csr_bits = ^{csr_enable_i, csr_reset_i, csr_uaddr_i};

  always_ff @(posedge clk_sys_i) begin
    if (iram_we) begin
      iram[uaddr] <= csr_udata_i;
    end
  end

  always_comb begin
    cpu_rst_n_d = ~rst_bit;
    cpu_en_d    = csr_enable_i[g_cpu_id] & ~rst_bit;
    im_data_d   = im_data_q;
    // Read sees the pre-edge contents, so a colliding upload returns old data.
    if (im_rd_i && cpu_rst_n_q) begin
      im_data_d = iram[im_addr_i];
    end
  end

  always_comb begin
    dm_data_d    = dm_data_q;
    shadow_tai_d = shadow_tai_q;
    shadow_cyc_d = shadow_cyc_q;
    if (dm_rd_i) begin
      case (dm_addr_i)
        2'd0: begin
          dm_data_d    = tm_tai_i[31:0];
          shadow_tai_d = tm_tai_i[39:32];
          shadow_cyc_d = tm_cycles_i;
        end
        2'd1:    dm_data_d = {24'b0, shadow_tai_q};
        2'd2:    dm_data_d = {4'b0, shadow_cyc_q};
        default: dm_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cpu_rst_n_q  <= 1'b0;
      cpu_en_q     <= 1'b0;
      im_data_q    <= '0;
      dm_data_q    <= '0;
      shadow_tai_q <= '0;
      shadow_cyc_q <= '0;
    end else begin
      cpu_rst_n_q  <= cpu_rst_n_d;
      cpu_en_q     <= cpu_en_d;
      im_data_q    <= im_data_d;
      dm_data_q    <= dm_data_d;
      shadow_tai_q <= shadow_tai_d;
      shadow_cyc_q <= shadow_cyc_d;
    end
  end

`ifdef WRN_CPU_CB_READBACK_EN
  logic [31:0] csr_udata_d, csr_udata_q;

  assign csr_udata_d = iram[uaddr];

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      csr_udata_q <= '0;
    end else begin
      csr_udata_q <= csr_udata_d;
    end
  end

  assign csr_udata_o = csr_udata_q;
`else
  assign csr_udata_o = '0;
`endif

  assign cpu_rst_n_o = cpu_rst_n_q;
  assign cpu_en_o    = cpu_en_q;
  assign im_data_o   = im_data_q;
  assign dm_data_o   = dm_data_q;

endmodule

// File: tb/tb_wr_node_cpu_cb.sv
// Testbench for wr_node_cpu_cb: directed vector table, async reset sequence, randomized run vs reference model.
// Readback expectations follow WRN_CPU_CB_READBACK_EN the same way the design does.
module tb_wr_node_cpu_cb;
  localparam int NW     = 4096;
  localparam int AW     = 12;
  localparam int CPU_ID = 0;

  logic          clk_sys_i = 1'b0;
  logic          rst_n_i;
  logic [39:0]   tm_tai_i;
  logic [27:0]   tm_cycles_i;
  logic [3:0]    csr_core_sel_i;
  logic [7:0]    csr_enable_i;
  logic [7:0]    csr_reset_i;
  logic [19:0]   csr_uaddr_i;
  logic [31:0]   csr_udata_i;
  logic          csr_udata_load_i;
  logic [31:0]   csr_udata_o;
  logic          im_rd_i;
  logic [AW-1:0] im_addr_i;
  logic [31:0]   im_data_o;
  logic          dm_rd_i;
  logic [1:0]    dm_addr_i;
  logic [31:0]   dm_data_o;
  logic          cpu_rst_n_o;
  logic          cpu_en_o;

  wr_node_cpu_cb #(.g_iram_size(16384), .g_cpu_id(CPU_ID)) dut (
    .clk_sys_i(clk_sys_i), .rst_n_i(rst_n_i),
    .tm_tai_i(tm_tai_i), .tm_cycles_i(tm_cycles_i),
    .csr_core_sel_i(csr_core_sel_i), .csr_enable_i(csr_enable_i), .csr_reset_i(csr_reset_i),
    .csr_uaddr_i(csr_uaddr_i), .csr_udata_i(csr_udata_i), .csr_udata_load_i(csr_udata_load_i),
    .csr_udata_o(csr_udata_o),
    .im_rd_i(im_rd_i), .im_addr_i(im_addr_i), .im_data_o(im_data_o),
    .dm_rd_i(dm_rd_i), .dm_addr_i(dm_addr_i), .dm_data_o(dm_data_o),
    .cpu_rst_n_o(cpu_rst_n_o), .cpu_en_o(cpu_en_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  int checks = 0;
  int failures = 0;

  // Reference model: word-addressed memory with known-flags plus the architectural outputs.
  logic [31:0] m_mem [NW];
  bit          m_ok  [NW];
  logic        m_rst_n, m_en;
  logic [31:0] m_im, m_dm, m_rb;
  bit          m_im_ok, m_rb_ok;
  logic [7:0]  m_sh_tai;
  logic [27:0] m_sh_cyc;

  typedef struct {
    logic rst; logic en; logic [3:0] sel; logic ld; logic [19:0] ua; logic [31:0] ud;
    logic ird; logic [AW-1:0] ia; logic drd; logic [1:0] da; logic [39:0] tai; logic [27:0] cyc;
    logic ci; logic [31:0] ei; logic cd; logic [31:0] ed; logic erst; logic een;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t mk(logic rst, logic en, logic [3:0] sel, logic ld, logic [19:0] ua,
                              logic [31:0] ud, logic ird, logic [AW-1:0] ia, logic drd, logic [1:0] da,
                              logic [39:0] tai, logic [27:0] cyc, logic ci, logic [31:0] ei,
                              logic cd, logic [31:0] ed, logic erst, logic een);
    vec_t v;
    v.rst = rst; v.en = en; v.sel = sel; v.ld = ld; v.ua = ua; v.ud = ud;
    v.ird = ird; v.ia = ia; v.drd = drd; v.da = da; v.tai = tai; v.cyc = cyc;
    v.ci = ci; v.ei = ei; v.cd = cd; v.ed = ed; v.erst = erst; v.een = een;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rst_n = 1'b0; m_en = 1'b0;
    m_im = '0; m_im_ok = 1'b1;
    m_dm = '0; m_rb = '0; m_rb_ok = 1'b1;
    m_sh_tai = '0; m_sh_cyc = '0;
  endtask

  // Advance one clock: evaluate the rules on the pre-edge inputs, then land 1 time unit after the edge.
  task automatic step();
    int unsigned ua;
    bit          sel, rbit;
    ua   = 32'(csr_uaddr_i) % NW;
    sel  = (csr_core_sel_i == 4'(CPU_ID));
    rbit = csr_reset_i[CPU_ID];
    if (rst_n_i) begin
      if (im_rd_i && m_rst_n) begin
        m_im    = m_mem[im_addr_i];
        m_im_ok = m_ok[im_addr_i];
      end
      if (dm_rd_i) begin
        if (dm_addr_i == 2'd0) begin
          m_dm     = tm_tai_i[31:0];
          m_sh_tai = tm_tai_i[39:32];
          m_sh_cyc = tm_cycles_i;
        end else if (dm_addr_i == 2'd1) m_dm = 32'(m_sh_tai);
        else if (dm_addr_i == 2'd2)     m_dm = 32'(m_sh_cyc);
        else                            m_dm = 32'h0;
      end
`ifdef WRN_CPU_CB_READBACK_EN
      m_rb    = m_mem[ua];
      m_rb_ok = m_ok[ua];
`endif
      if (csr_udata_load_i && sel && rbit) begin
        m_mem[ua] = csr_udata_i;
        m_ok[ua]  = 1'b1;
      end
      m_rst_n = !rbit;
      m_en    = csr_enable_i[CPU_ID] && !rbit;
    end
    @(posedge clk_sys_i);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_rst_n"}, 32'(cpu_rst_n_o), 32'(m_rst_n));
    chk({tag, "_en"},    32'(cpu_en_o),    32'(m_en));
    chk({tag, "_dm"},    dm_data_o,        m_dm);
    if (m_im_ok) chk({tag, "_im"}, im_data_o, m_im);
    if (m_rb_ok) chk({tag, "_rb"}, csr_udata_o, m_rb);
  endtask

  initial begin
    logic [7:0] rv;
    logic       rbit;

    for (int i = 0; i < NW; i++) begin m_mem[i] = '0; m_ok[i] = 1'b0; end
    model_reset();

    rst_n_i = 1'b0; tm_tai_i = '0; tm_cycles_i = '0; csr_core_sel_i = '0; csr_enable_i = '0;
    csr_reset_i = '0; csr_uaddr_i = '0; csr_udata_i = '0; csr_udata_load_i = 1'b0;
    im_rd_i = 1'b0; im_addr_i = '0; dm_rd_i = 1'b0; dm_addr_i = '0;

    repeat (3) @(posedge clk_sys_i);
    #1;
    chk("reset_rst_n", 32'(cpu_rst_n_o), 32'h0);
    chk("reset_en",    32'(cpu_en_o),    32'h0);
    chk("reset_im",    im_data_o,        32'h0);
    chk("reset_dm",    dm_data_o,        32'h0);
    chk("reset_rb",    csr_udata_o,      32'h0);
    rst_n_i = 1'b1;

    //         rst en sel ld  ua        ud             ird ia    drd da  tai              cyc  ci ei             cd ed            erst een
    vec.push_back(mk(1, 0, 0, 1, 0,        32'hDEADBEEF, 0, 0,    0, 0, 0,               0,   0, 0,             0, 0,            0, 0));
    vec.push_back(mk(1, 0, 0, 1, 1,        32'h00000013, 0, 0,    0, 0, 0,               0,   0, 0,             0, 0,            0, 0));
    vec.push_back(mk(1, 0, 0, 1, 4095,     32'hCAFEF00D, 0, 0,    0, 0, 0,               0,   0, 0,             0, 0,            0, 0));
    vec.push_back(mk(1, 0, 0, 1, 5,        32'h55555555, 0, 0,    0, 0, 0,               0,   0, 0,             0, 0,            0, 0));
    vec.push_back(mk(1, 0, 0, 1, 7,        32'h00000000, 0, 0,    0, 0, 0,               0,   0, 0,             0, 0,            0, 0));
    vec.push_back(mk(0, 1, 0, 0, 0,        0,            0, 0,    0, 0, 0,               0,   0, 0,             0, 0,            1, 1));
    vec.push_back(mk(0, 1, 0, 0, 0,        0,            1, 0,    0, 0, 0,               0,   1, 32'hDEADBEEF,  0, 0,            1, 1));
    vec.push_back(mk(0, 1, 0, 0, 0,        0,            1, 1,    0, 0, 0,               0,   1, 32'h00000013,  0, 0,            1, 1));
    vec.push_back(mk(0, 1, 0, 0, 0,        0,            1, 4095, 0, 0, 0,               0,   1, 32'hCAFEF00D,  0, 0,            1, 1));
    vec.push_back(mk(0, 1, 0, 1, 5,        32'h11111111, 0, 0,    0, 0, 0,               0,   1, 32'hCAFEF00D,  0, 0,            1, 1));
    vec.push_back(mk(1, 1, 1, 1, 5,        32'h11111111, 0, 0,    0, 0, 0,               0,   0, 0,             0, 0,            0, 0));
    vec.push_back(mk(1, 1, 0, 1, 4096 + 7, 32'hA5A5A5A5, 0, 0,    0, 0, 0,               0,   0, 0,             0, 0,            0, 0));
    vec.push_back(mk(0, 1, 0, 0, 0,        0,            0, 0,    0, 0, 0,               0,   0, 0,             0, 0,            1, 1));
    vec.push_back(mk(0, 1, 0, 0, 0,        0,            1, 5,    0, 0, 0,               0,   1, 32'h55555555,  0, 0,            1, 1));
    vec.push_back(mk(0, 1, 0, 0, 0,        0,            1, 7,    0, 0, 0,               0,   1, 32'hA5A5A5A5,  0, 0,            1, 1));
    vec.push_back(mk(0, 1, 0, 0, 0,        0,            0, 0,    0, 0, 0,               0,   1, 32'hA5A5A5A5,  0, 0,            1, 1));
    vec.push_back(mk(0, 0, 0, 0, 0,        0,            0, 0,    0, 0, 0,               0,   0, 0,             0, 0,            1, 0));
    vec.push_back(mk(0, 0, 0, 0, 0,        0,            0, 0,    1, 0, 40'h123456789A, 999, 0, 0,             1, 32'h3456789A, 1, 0));
    vec.push_back(mk(0, 0, 0, 0, 0,        0,            0, 0,    1, 1, 40'h1300000000, 5,   0, 0,             1, 32'h00000012, 1, 0));
    vec.push_back(mk(0, 0, 0, 0, 0,        0,            0, 0,    1, 3, 40'h1300000000, 5,   0, 0,             1, 32'h00000000, 1, 0));
    vec.push_back(mk(0, 0, 0, 0, 0,        0,            0, 0,    1, 2, 40'h1300000000, 5,   0, 0,             1, 32'd999,      1, 0));
    vec.push_back(mk(0, 0, 0, 0, 0,        0,            0, 0,    0, 0, 40'h1300000000, 5,   0, 0,             1, 32'd999,      1, 0));
    vec.push_back(mk(0, 0, 0, 0, 0,        0,            0, 0,    1, 0, 40'h1300000000, 5,   0, 0,             1, 32'h00000000, 1, 0));
    vec.push_back(mk(0, 0, 0, 0, 0,        0,            0, 0,    1, 1, 40'h1300000000, 5,   0, 0,             1, 32'h00000013, 1, 0));
    vec.push_back(mk(1, 1, 0, 1, 0,        32'h12345678, 1, 0,    0, 0, 0,               0,   1, 32'hDEADBEEF,  0, 0,            0, 0));
    vec.push_back(mk(0, 1, 0, 0, 0,        0,            0, 0,    0, 0, 0,               0,   1, 32'hDEADBEEF,  0, 0,            1, 1));
    vec.push_back(mk(0, 1, 0, 0, 0,        0,            1, 0,    0, 0, 0,               0,   1, 32'h12345678,  0, 0,            1, 1));
    vec.push_back(mk(1, 1, 0, 0, 0,        0,            0, 0,    0, 0, 0,               0,   1, 32'h12345678,  0, 0,            0, 0));
    vec.push_back(mk(1, 1, 0, 0, 0,        0,            1, 1,    0, 0, 0,               0,   1, 32'h12345678,  0, 0,            0, 0));
    vec.push_back(mk(0, 0, 0, 0, 0,        0,            0, 0,    0, 0, 0,               0,   0, 0,             0, 0,            1, 0));

    foreach (vec[i]) begin
      csr_reset_i      = {7'b0, vec[i].rst};
      csr_enable_i     = {7'b0, vec[i].en};
      csr_core_sel_i   = vec[i].sel;
      csr_udata_load_i = vec[i].ld;
      csr_uaddr_i      = vec[i].ua;
      csr_udata_i      = vec[i].ud;
      im_rd_i          = vec[i].ird;
      im_addr_i        = vec[i].ia;
      dm_rd_i          = vec[i].drd;
      dm_addr_i        = vec[i].da;
      tm_tai_i         = vec[i].tai;
      tm_cycles_i      = vec[i].cyc;
      step();
      chk($sformatf("vec%0d_rst_n", i), 32'(cpu_rst_n_o), 32'(vec[i].erst));
      chk($sformatf("vec%0d_en", i),    32'(cpu_en_o),    32'(vec[i].een));
      if (vec[i].ci) chk($sformatf("vec%0d_im", i), im_data_o, vec[i].ei);
      if (vec[i].cd) chk($sformatf("vec%0d_dm", i), dm_data_o, vec[i].ed);
    end

    // Block reset asserted in the middle of an upload cycle.
    csr_reset_i = 8'h01; csr_enable_i = 8'h01; csr_core_sel_i = 4'd0;
    csr_udata_load_i = 1'b1; csr_uaddr_i = 20'd0; csr_udata_i = 32'hFFFFFFFF;
    im_rd_i = 1'b0; dm_rd_i = 1'b0;
    #2;
    rst_n_i = 1'b0;
    model_reset();
    #1;
    chk("arst_rst_n", 32'(cpu_rst_n_o), 32'h0);
    chk("arst_en",    32'(cpu_en_o),    32'h0);
    chk("arst_im",    im_data_o,        32'h0);
    chk("arst_dm",    dm_data_o,        32'h0);
    chk("arst_rb",    csr_udata_o,      32'h0);
    step();
    chk("arst_hold_im", im_data_o, 32'h0);
    rst_n_i = 1'b1;
    csr_udata_load_i = 1'b0; csr_reset_i = 8'h00; csr_uaddr_i = 20'd1;
    step();
    chk("arst_rel_rst_n", 32'(cpu_rst_n_o), 32'h1);
    chk("arst_rel_en",    32'(cpu_en_o),    32'h1);
`ifdef WRN_CPU_CB_READBACK_EN
    chk("arst_rb_word1", csr_udata_o, 32'h00000013);
`else
    chk("arst_rb_word1", csr_udata_o, 32'h0);
`endif
    im_rd_i = 1'b1; im_addr_i = '0;
    step();
    chk("arst_retained_w0", im_data_o, 32'h12345678);
    check_model("arst");

    // Randomized run against the reference model.
    rbit = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) rbit = ~rbit;
      rv = 8'($urandom);
      rv[0] = rbit;
      csr_reset_i      = rv;
      csr_enable_i     = 8'($urandom);
      csr_core_sel_i   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      csr_udata_load_i = 1'($urandom_range(0, 1));
      csr_uaddr_i      = 20'($urandom_range(0, 15) + NW * $urandom_range(0, 255));
      csr_udata_i      = $urandom;
      im_rd_i          = 1'($urandom_range(0, 1));
      im_addr_i        = AW'($urandom_range(0, 15));
      dm_rd_i          = 1'($urandom_range(0, 1));
      dm_addr_i        = 2'($urandom_range(0, 3));
      tm_tai_i         = {8'($urandom), 32'($urandom)};
      tm_cycles_i      = 28'($urandom);
      step();
      check_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wr_node_cpu_cb.md
# wr_node_cpu_cb

CPU control block for one White Rabbit node core CPU. It owns the CPU's instruction RAM and lets the host upload firmware through CSR fields while the core is held in reset. It generates the core's reset and enable from per-core CSR bits and gives the CPU a small read-only timestamp port fed by the WR timing interface. It sits between the node's CPU CSR block and a single soft-CPU core.

## Interface

Parameters:
- g_iram_size, 16384: IRAM size in bytes; power of two; IRAM holds NW = g_iram_size/4 32-bit words; AW = log2(NW).
- g_cpu_id, 0: index of this core, range 0..7; selects the CSR bits this block responds to.

Ports:
- clk_sys_i  in  1  system clock; all logic is on its rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- tm_tai_i  in  40  TAI seconds, already synchronous to clk_sys_i.
- tm_cycles_i  in  28  sub-second cycle count, synchronous to clk_sys_i.
- csr_core_sel_i  in  4  core selected for upload.
- csr_enable_i  in  8  per-core enable bits.
- csr_reset_i  in  8  per-core reset bits; 1 holds the core in reset.
- csr_uaddr_i  in  20  upload word address.
- csr_udata_i  in  32  upload data.
- csr_udata_load_i  in  1  single-cycle upload write strobe.
- csr_udata_o  out  32  IRAM readback at csr_uaddr_i.
- im_rd_i  in  1  instruction fetch strobe.
- im_addr_i  in  AW  instruction word address.
- im_data_o  out  32  fetched instruction.
- dm_rd_i  in  1  timestamp port read strobe.
- dm_addr_i  in  2  timestamp register index.
- dm_data_o  out  32  timestamp read data.
- cpu_rst_n_o  out  1  core reset, active low.
- cpu_en_o  out  1  core run enable; 0 stalls the core.

## Operation

- Let sel = (csr_core_sel_i == g_cpu_id) and rst_bit = csr_reset_i[g_cpu_id].
- Upload: on an edge with csr_udata_load_i=1, sel=1 and rst_bit=1, IRAM[csr_uaddr_i mod NW] is written with csr_udata_i.
- An upload strobe is ignored when rst_bit=0 or sel=0.
- Addresses wrap modulo NW.
- Fetch: when im_rd_i=1, im_data_o is set to IRAM[im_addr_i]. Otherwise im_data_o holds its value.
- Fetch has no effect while cpu_rst_n_o=0.
- If a fetch and an upload hit the same address in the same cycle, the fetch returns the old data (read-before-write).
- cpu_rst_n_o is the registered value of !rst_bit.
- cpu_en_o is the registered value of csr_enable_i[g_cpu_id] & !rst_bit.
- Timestamp registers (dm_addr_i):
  - 0: TAI[31:0]. Reading it also latches TAI[39:32] and tm_cycles_i into a shadow register.
  - 1: {24'b0, latched TAI[39:32]}.
  - 2: {4'b0, latched cycles}.
  - 3: reads 0x00000000.
- The timestamp read data is the registered result when dm_rd_i=1; otherwise dm_data_o holds.
- IRAM contents are not initialised and are not cleared by reset.

## Timing

- Reset (rst_n_i=0, asynchronous):
  - cpu_rst_n_o=0 and cpu_en_o=0.
  - im_data_o, dm_data_o, csr_udata_o and the shadow register are all 0.
  - Upload writes are blocked.
- Upload write takes effect on the edge where the strobe is sampled. A readback of that word is valid 2 cycles later.
- Fetch latency is 1 cycle, strobe to im_data_o. Back-to-back fetches sustain one word per cycle.
- cpu_rst_n_o and cpu_en_o follow the CSR bits with 1-cycle latency.
- Setting rst_bit mid-run forces cpu_rst_n_o=0 and cpu_en_o=0 on the next edge. Enable alone never releases reset.
- Timestamp read latency is 1 cycle. The shadow register updates on the same edge as the register-0 read.

## Configuration

- WRN_CPU_CB_READBACK_EN defined: csr_udata_o is registered each cycle to IRAM[csr_uaddr_i mod NW], giving 1-cycle latency from the address. This uses a second RAM read port.
- Not defined: csr_udata_o is constant 0 and there is no second RAM read port.

## Test plan

- Reset held and core_sel=0: write 0xDEADBEEF@0, 0x00000013@1, 0xCAFEF00D@4095; clear reset; fetch addresses 0, 1, 4095 -> im_data_o = 0xDEADBEEF, 0x00000013, 0xCAFEF00D, each 1 cycle after its strobe.
- Upload 0x11111111@5 with reset_bit=0, then with core_sel=1 -> a later fetch of word 5 returns its prior value; with readback enabled, csr_udata_o@5 also unchanged.
- Upload 0xA5A5A5A5 at uaddr=4096+7 -> word 7 reads 0xA5A5A5A5.
- reset[0]=1, enable[0]=1 -> cpu_rst_n_o=0 and cpu_en_o=0. Clear reset -> both read 1 one cycle later. Set reset -> both read 0 one cycle after.
- tm_tai_i=0x12_3456789A, tm_cycles_i=999: read reg0 -> 0x3456789A. Change tai to 0x13_00000000 and cycles to 5; read reg1 -> 0x12; read reg2 -> 999.
- Assert rst_n_i mid-upload -> all outputs 0 immediately. Previously written IRAM words are retained; readback shows them after release (WRN_CPU_CB_READBACK_EN builds).
